// File: rtl/button_event_if.sv
`default_nettype none
// ============================================================================
// Module   : button_event_if
// Brief    : Single-entry button event handshake (valid/ready, code, overflow)
// Revision : 1.0 - initial release
// ============================================================================
interface button_event_if;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready;
  logic       evt_ovf;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_ovf,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_ovf,
    output evt_ready
  );
endinterface
`default_nettype wire

// File: rtl/button_event.sv
`default_nettype none
// ============================================================================
// Module   : button_event
// Brief    : Decodes a debounced button into press/release/hold/repeat events.
//            Repeat generation is enabled by the macro BUTTON_EVENT_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module button_event #(
  parameter bit PB_ACTIVE_LOW = 1'b1,
  parameter int HOLD_TICKS    = 50,
  parameter int REPEAT_TICKS  = 10,
  parameter int CNT_W         = 8
) (
  input  wire logic      clock,
  input  wire logic      rst_n,
  input  wire logic      tick,
  input  wire logic      pb_level,
  output logic           press,
  output logic           release_pulse,
  output logic           hold,
  output logic           repeat_pulse,
  output logic           pressed,
  button_event_if.master evt
);

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_pressed = 2'd1;
  localparam logic [1:0] c_st_repeat  = 2'd2;

  localparam logic [1:0] c_ev_press   = 2'd0;
  localparam logic [1:0] c_ev_release = 2'd1;
  localparam logic [1:0] c_ev_hold    = 2'd2;
  localparam logic [1:0] c_ev_repeat  = 2'd3;

  localparam logic             c_idle_level = PB_ACTIVE_LOW;
  localparam logic [CNT_W-1:0] c_hold_last  = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] c_rep_last   = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

`ifdef BUTTON_EVENT_REPEAT_EN
  localparam bit c_repeat_en = 1'b1;
`else
  localparam bit c_repeat_en = 1'b0;
`endif

  logic             r_sync1;
  logic             r_sync2;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ev_fire;
  logic [1:0]       r_ev_code;
  logic             r_evt_valid;
  logic [1:0]       r_evt_code;
  logic             r_evt_ovf;

  logic             w_p;
  logic [1:0]       w_next_state;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_ev_fire;
  logic [1:0]       w_ev_code;

  // XOR with the polarity turns the synchronized level into active-high "pressed"
  assign w_p = r_sync2 ^ PB_ACTIVE_LOW;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= c_idle_level;
      r_sync2   <= c_idle_level;
      r_state   <= c_st_idle;
      r_cnt     <= '0;
      r_ev_fire <= 1'b0;
      r_ev_code <= c_ev_press;
    end else begin
      r_sync1   <= pb_level;
      r_sync2   <= r_sync1;
      r_state   <= w_next_state;
      r_cnt     <= w_next_cnt;
      r_ev_fire <= w_ev_fire;
      r_ev_code <= w_ev_code;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_ev_fire    = 1'b0;
    w_ev_code    = c_ev_press;
    case (r_state)
      c_st_idle: begin
        if (w_p) begin
          w_next_state = c_st_pressed;
          w_next_cnt   = '0;
          w_ev_fire    = 1'b1;
          w_ev_code    = c_ev_press;
        end
      end
      c_st_pressed: begin
        // release is checked first so it wins over a hold due on the same tick
        if (!w_p) begin
          w_next_state = c_st_idle;
          w_next_cnt   = '0;
          w_ev_fire    = 1'b1;
          w_ev_code    = c_ev_release;
        end else if (tick) begin
          if (r_cnt == c_hold_last) begin
            w_next_state = c_st_repeat;
            w_next_cnt   = '0;
            w_ev_fire    = 1'b1;
            w_ev_code    = c_ev_hold;
          end else begin
            w_next_cnt = r_cnt + c_cnt_one;
          end
        end
      end
      c_st_repeat: begin
        if (!w_p) begin
          w_next_state = c_st_idle;
          w_next_cnt   = '0;
          w_ev_fire    = 1'b1;
          w_ev_code    = c_ev_release;
        end else if (tick && c_repeat_en) begin
          if (r_cnt == c_rep_last) begin
            w_next_cnt = '0;
            w_ev_fire  = 1'b1;
            w_ev_code  = c_ev_repeat;
          end else begin
            w_next_cnt = r_cnt + c_cnt_one;
          end
        end
      end
      default: begin
        w_next_state = c_st_idle;
        w_next_cnt   = '0;
      end
    endcase
  end

  always_comb begin
    pressed       = (r_state != c_st_idle);
    press         = r_ev_fire && (r_ev_code == c_ev_press);
    release_pulse = r_ev_fire && (r_ev_code == c_ev_release);
    hold          = r_ev_fire && (r_ev_code == c_ev_hold);
`ifdef BUTTON_EVENT_REPEAT_EN
    repeat_pulse  = r_ev_fire && (r_ev_code == c_ev_repeat);
`else
    repeat_pulse  = 1'b0;
`endif
  end

  // A new event while the slot is full and not being taken is dropped
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_valid <= 1'b0;
      r_evt_code  <= c_ev_press;
      r_evt_ovf   <= 1'b0;
    end else if (w_ev_fire) begin
      if (!r_evt_valid || evt.evt_ready) begin
        r_evt_valid <= 1'b1;
        r_evt_code  <= w_ev_code;
      end else begin
        r_evt_ovf <= 1'b1;
      end
    end else if (r_evt_valid && evt.evt_ready) begin
      r_evt_valid <= 1'b0;
    end
  end

  assign evt.evt_valid = r_evt_valid;
  assign evt.evt_code  = r_evt_code;
  assign evt.evt_ovf   = r_evt_ovf;

endmodule
`default_nettype wire

// File: tb/tb_button_event.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_event
// Brief    : Scoreboard bench for button_event with a tick-count reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_event;
  localparam int HOLD = 5;
  localparam int REP  = 2;
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif
  localparam logic IDLE_LVL = 1'b1;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic tick  = 1'b0;
  logic pb_level = IDLE_LVL;
  logic ready_drv = 1'b1;
  logic press, release_pulse, hold, repeat_pulse, pressed;

  button_event_if bif ();
  assign bif.evt_ready = ready_drv;

  button_event #(
    .PB_ACTIVE_LOW (1'b1),
    .HOLD_TICKS    (HOLD),
    .REPEAT_TICKS  (REP),
    .CNT_W         (8)
  ) dut (
    .clock         (clock),
    .rst_n         (rst_n),
    .tick          (tick),
    .pb_level      (pb_level),
    .press         (press),
    .release_pulse (release_pulse),
    .hold          (hold),
    .repeat_pulse  (repeat_pulse),
    .pressed       (pressed),
    .evt           (bif.master)
  );

  always #5 clock = ~clock;

  typedef struct {
    int cyc;
    int code;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hold_seen = 0;
  int rep_seen = 0;
  int rep_expected = 0;

  bit rand_ready  = 1'b0;
  bit ready_force = 1'b1;
  int tick_div    = 0;

  // reference model state
  logic h0 = IDLE_LVL;
  logic h1 = IDLE_LVL;
  bit   m_pressed = 1'b0;
  int   m_ticks = 0;
  bit   m_valid = 1'b0;
  int   m_code = 0;
  bit   m_ovf = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // tick every 4 clocks; ready either forced or random
  always @(negedge clock) begin
    tick_div  = (tick_div + 1) % 4;
    tick      = (tick_div == 0);
    ready_drv = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // Model: events follow from the 2-clock delayed level and the number of
  // ticks seen since the press began.
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      h0 = IDLE_LVL;
      h1 = IDLE_LVL;
      m_pressed = 1'b0;
      m_ticks = 0;
      m_valid = 1'b0;
      m_code = 0;
      m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      bit p;
      bit ev;
      int code;
      p = (h1 != IDLE_LVL);
      ev = 1'b0;
      code = 0;
      if (!m_pressed && p) begin
        m_pressed = 1'b1;
        m_ticks = 0;
        ev = 1'b1;
        code = 0;
      end else if (m_pressed && !p) begin
        m_pressed = 1'b0;
        ev = 1'b1;
        code = 1;
      end else if (m_pressed && tick) begin
        m_ticks++;
        if (m_ticks == HOLD) begin
          ev = 1'b1;
          code = 2;
        end else if (REP_EN && m_ticks > HOLD && ((m_ticks - HOLD) % REP) == 0) begin
          ev = 1'b1;
          code = 3;
          rep_expected++;
        end
      end
      if (ev) begin
        exp_q.push_back('{cyc: cyc + 1, code: code});
        if (!m_valid || ready_drv) begin
          m_valid = 1'b1;
          m_code = code;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_valid && ready_drv) begin
        m_valid = 1'b0;
      end
      h1 = h0;
      h0 = pb_level;
    end
  end

  // Monitor: pops an expectation whenever the DUT shows a pulse
  always @(negedge clock) begin
    if (rst_n) begin
      int npulse;
      int code;
      exp_t e;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        check("missing_event_code", -1, e.code);
      end
      npulse = int'(press) + int'(release_pulse) + int'(hold) + int'(repeat_pulse);
      if (npulse > 0) begin
        code = release_pulse ? 1 : hold ? 2 : repeat_pulse ? 3 : 0;
        if (hold) hold_seen++;
        if (repeat_pulse) rep_seen++;
        check("pulse_count", npulse, 1);
        check("expected_queue_nonempty", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("event_code", code, e.code);
          check("event_cycle", cyc, e.cyc);
        end
      end
      check("pressed", int'(pressed), int'(m_pressed));
      check("evt_valid", int'(bif.evt_valid), int'(m_valid));
      if (m_valid) check("evt_code", int'(bif.evt_code), m_code);
      check("evt_ovf", int'(bif.evt_ovf), int'(m_ovf));
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_press"}, int'(press), 0);
    check({tag, "_release"}, int'(release_pulse), 0);
    check({tag, "_hold"}, int'(hold), 0);
    check({tag, "_repeat"}, int'(repeat_pulse), 0);
    check({tag, "_pressed"}, int'(pressed), 0);
    check({tag, "_evt_valid"}, int'(bif.evt_valid), 0);
    check({tag, "_evt_code"}, int'(bif.evt_code), 0);
    check({tag, "_evt_ovf"}, int'(bif.evt_ovf), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h_before;
    int r_before;
    int budget;

    wait_clk(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    wait_clk(4);

    // long press through hold (and repeats when enabled)
    pb_level = 1'b0;
    wait_clk(3);
    check("press_pulse_latency", int'(press), 1);
    check("pressed_after_press", int'(pressed), 1);
    wait_clk(40);
    pb_level = 1'b1;
    wait_clk(10);
    check("long_press_holds", hold_seen, 1);
    check("pressed_after_release", int'(pressed), 0);

    // short press: no hold
    pb_level = 1'b0;
    wait_clk(12);
    pb_level = 1'b1;
    wait_clk(10);
    check("short_press_no_hold", hold_seen, 1);

    // consumer stalled: release is dropped, overflow sticks
    ready_force = 1'b0;
    wait_clk(2);
    pb_level = 1'b0;
    wait_clk(8);
    pb_level = 1'b1;
    wait_clk(8);
    check("stall_evt_code", int'(bif.evt_code), 0);
    check("stall_evt_ovf", int'(bif.evt_ovf), 1);
    ready_force = 1'b1;
    wait_clk(2);
    check("ready_clears_valid", int'(bif.evt_valid), 0);
    wait_clk(4);

    // release coincident with the tick that would complete the hold
    h_before = hold_seen;
    pb_level = 1'b0;
    budget = 0;
    while (!(m_pressed && m_ticks == HOLD - 1) && budget < 200) begin
      wait_clk(1);
      budget++;
    end
    check("coincident_setup_in_budget", int'(budget < 200), 1);
    wait_clk(1);
    pb_level = 1'b1;
    wait_clk(10);
    check("coincident_no_hold", hold_seen, h_before);

    // hold for 20 ticks: exactly one hold, repeats only when enabled
    h_before = hold_seen;
    r_before = rep_seen;
    pb_level = 1'b0;
    wait_clk(85);
    pb_level = 1'b1;
    wait_clk(10);
    check("long20_one_hold", hold_seen - h_before, 1);
    check("long20_repeat_total", rep_seen, rep_expected);
    check("repeat_total_vs_build", int'(rep_seen > r_before), int'(REP_EN));

    // reset mid-press: outputs drop immediately, press re-detected afterwards
    pb_level = 1'b0;
    wait_clk(20);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(10);
    check("press_after_reset", int'(pressed), 1);
    pb_level = 1'b1;
    wait_clk(10);

    // randomized presses with a randomly stalling consumer
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      pb_level = ~pb_level;
      wait_clk($urandom_range(1, 60));
    end
    pb_level = 1'b1;
    rand_ready = 1'b0;
    wait_clk(20);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
